// File: rtl/ppm_encoder.sv
// ppm_encoder: 8-channel PPM frame generator.
//
// Purpose
//   Produces a standard RC-style PPM stream. Each frame is 8 channel periods,
//   a closing pulse and a sync gap. A channel period starts with a PULSE_US
//   separator pulse at the pulse level. The rest of the period is idle level.
//   Every duration is counted in 1 us ticks taken from a CLK_DIV prescaler.
//
// Parameters
//   CLK_DIV      CLK cycles per 1 us tick
//   FRAME_US     nominal frame length in us
//   PULSE_US     separator pulse width in us
//   SYNC_MIN_US  minimum sync gap in us
//   DEFAULT_US   channel value loaded at reset
//
// Ports
//   CLK          the only clock
//   RSTn         asynchronous active-low reset
//   En           encoder enable; low forces IDLE on the next cycle
//   Dat_In       8 x 11-bit channel values in us, channel k at [11k+10:11k]
//   Dat_Rdy      one-cycle strobe that marks Dat_In valid
//   Sig_Out      PPM stream (idle high, pulse low unless PPM_INVERT_EN)
//   Frame_Start  one-cycle pulse on the first PULSE cycle of channel 0
//   state_dbg    current FSM state encoding (observation only)
//
// Handshake: Dat_Rdy is a fire-and-forget strobe with no ready/back-pressure.
//   On every cycle with Dat_Rdy=1, the clamped Dat_In is captured into the
//   pending set. A later strobe overwrites it. The pending set moves to the
//   active set only in LOAD, so a frame in progress never changes.
//
// Configuration macro
//   PPM_INVERT_EN  when defined, Sig_Out is inverted at the output. The idle
//                  level becomes low and the pulse level becomes high. Timing
//                  is the same in both builds.

module ppm_encoder #(
    parameter int CLK_DIV     = 50,
    parameter int FRAME_US    = 20000,
    parameter int PULSE_US    = 400,
    parameter int SYNC_MIN_US = 3000,
    parameter int DEFAULT_US  = 1500
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        En,
    input  logic [87:0] Dat_In,
    input  logic        Dat_Rdy,
    output logic        Sig_Out,
    output logic        Frame_Start,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PULSE = 3'd2,
        S_SPACE = 3'd3,
        S_SYNC  = 3'd4
    } state_t;

    localparam int               PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [11:0]      CH_MIN   = 12'd800;
    localparam logic [11:0]      CH_MAX   = 12'd2200;
    localparam logic [11:0]      CH_RST   = 12'(DEFAULT_US);

    state_t           state, state_nxt;
    logic [PRE_W-1:0] pre_cnt;
    logic [15:0]      phase_us;   // us elapsed in the current phase
    logic [15:0]      elapsed;    // us since LOAD (pulses and spaces only)
    logic [15:0]      phase_dur;
    logic [15:0]      sync_us;
    logic [16:0]      sync_sum;
    logic [3:0]       idx;        // channel index 0..8; 8 = closing pulse
    logic [11:0]      active  [8];
    logic [11:0]      pending [8];
    logic             pend_flag;
    logic             timed, tick, phase_done, load_copy, sig_raw;

    // An 11-bit field cannot hold anything above 2047. The full-scale code
    // 2047 is treated as saturated and maps to the 2200 us upper limit.
    // Values below 800 are raised to 800.
    function automatic logic [11:0] clamp_ch(input logic [10:0] v);
        if (v == 11'h7FF)
            return CH_MAX;
        else if ({1'b0, v} < CH_MIN)
            return CH_MIN;
        else
            return {1'b0, v};
    endfunction

    // Sync gap is max(FRAME_US - elapsed, SYNC_MIN_US). The check is done as
    // elapsed + SYNC_MIN >= FRAME, so it works when elapsed > FRAME_US.
    always_comb begin
        sync_sum = {1'b0, elapsed} + 17'(SYNC_MIN_US);
        if (sync_sum >= 17'(FRAME_US))
            sync_us = 16'(SYNC_MIN_US);
        else
            sync_us = 16'(FRAME_US) - elapsed;
    end

    always_comb begin
        phase_dur = 16'd0;
        case (state)
            S_PULSE: phase_dur = 16'(PULSE_US);
            S_SPACE: phase_dur = 16'(active[idx[2:0]]) - 16'(PULSE_US);
            S_SYNC:  phase_dur = sync_us;
            default: phase_dur = 16'd0;
        endcase
    end

    assign timed      = (state == S_PULSE) || (state == S_SPACE) || (state == S_SYNC);
    assign tick       = timed && (pre_cnt == PRE_LAST);
    assign phase_done = tick && (phase_us == phase_dur - 16'd1);
    assign load_copy  = (state == S_LOAD) && En && pend_flag;

    // FSM: state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state and Moore outputs
    always_comb begin
        state_nxt   = state;
        sig_raw     = 1'b1;
        Frame_Start = 1'b0;
        if (!En) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_LOAD;
                S_LOAD:  state_nxt = S_PULSE;
                S_PULSE: if (phase_done) state_nxt = (idx == 4'd8) ? S_SYNC : S_SPACE;
                S_SPACE: if (phase_done) state_nxt = S_PULSE;
                S_SYNC:  if (phase_done) state_nxt = S_LOAD;
                default: state_nxt = S_IDLE;
            endcase
        end
        if (state == S_PULSE) begin
            sig_raw = 1'b0;
            // The first cycle of the channel-0 pulse is the only cycle where
            // both counters are zero, because LOAD clears them.
            Frame_Start = (idx == 4'd0) && (phase_us == 16'd0) && (pre_cnt == '0);
        end
    end

    // Prescaler, phase/elapsed counters, channel index, active set
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pre_cnt  <= '0;
            phase_us <= '0;
            elapsed  <= '0;
            idx      <= '0;
            for (int k = 0; k < 8; k++) active[k] <= CH_RST;
        end else if (!En) begin
            pre_cnt  <= '0;
            phase_us <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    pre_cnt  <= '0;
                    phase_us <= '0;
                    elapsed  <= '0;
                    idx      <= '0;
                    if (load_copy) active <= pending;
                end
                S_PULSE, S_SPACE, S_SYNC: begin
                    pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
                    if (tick) begin
                        phase_us <= phase_done ? 16'd0 : phase_us + 16'd1;
                        if (state != S_SYNC) elapsed <= elapsed + 16'd1;
                        if (phase_done && state == S_SPACE) idx <= idx + 4'd1;
                    end
                end
                default: begin
                    pre_cnt  <= '0;
                    phase_us <= '0;
                end
            endcase
        end
    end

    // Pending capture. A strobe in the same cycle as a LOAD copy keeps the
    // flag set, so the new data is used by the following frame.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pend_flag <= 1'b0;
            for (int k = 0; k < 8; k++) pending[k] <= CH_RST;
        end else if (Dat_Rdy) begin
            pend_flag <= 1'b1;
            for (int k = 0; k < 8; k++) pending[k] <= clamp_ch(Dat_In[11*k +: 11]);
        end else if (load_copy) begin
            pend_flag <= 1'b0;
        end
    end

`ifdef PPM_INVERT_EN
    assign Sig_Out = ~sig_raw;
`else
    assign Sig_Out = sig_raw;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_ppm_encoder.sv
`timescale 1ns/1ps
module tb_ppm_encoder;

    localparam int CLK_DIV     = 2;
    localparam int FRAME_US    = 7000;
    localparam int PULSE_US    = 100;
    localparam int SYNC_MIN_US = 300;
    localparam int DEFAULT_US  = 1000;

`ifdef PPM_INVERT_EN
    localparam logic IDLE_LVL = 1'b0;
`else
    localparam logic IDLE_LVL = 1'b1;
`endif
    localparam logic PULSE_LVL = ~IDLE_LVL;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_SPACE = 3'd3;

    logic        CLK;
    logic        RSTn;
    logic        En;
    logic [87:0] Dat_In;
    logic        Dat_Rdy;
    logic        Sig_Out;
    logic        Frame_Start;
    logic [2:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    // Expected runs: {level, frame_start count, length in cycles}
    logic [31:0] exp_q[$];
    logic        mon_on = 1'b0;

    // Stimulus vectors (raw) and hand-clamped expected channel values
    int raw_junk [8] = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
    int raw_b    [8] = '{0, 2047, 799, 801, 1234, 2046, 1500, 800};
    int exp_b    [8] = '{800, 2200, 800, 801, 1234, 2046, 1500, 800};
    int raw_c    [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int exp_c    [8] = '{800, 800, 800, 800, 800, 800, 800, 800};
    int exp_a    [8] = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};

    ppm_encoder #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_US   (FRAME_US),
        .PULSE_US   (PULSE_US),
        .SYNC_MIN_US(SYNC_MIN_US),
        .DEFAULT_US (DEFAULT_US)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .En         (En),
        .Dat_In     (Dat_In),
        .Dat_Rdy    (Dat_Rdy),
        .Sig_Out    (Sig_Out),
        .Frame_Start(Frame_Start),
        .state_dbg  (state_dbg)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] pk(input logic lvl, input int fs, input int len);
        return {lvl, 3'(fs), 28'(len)};
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One frame of expected runs. The sync high run also covers the LOAD cycle.
    task automatic push_frame(input int ch [8]);
        int el;
        int sy;
        el = 9 * PULSE_US;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(pk(PULSE_LVL, (k == 0) ? 1 : 0, PULSE_US * CLK_DIV));
            exp_q.push_back(pk(IDLE_LVL, 0, (ch[k] - PULSE_US) * CLK_DIV));
            el += ch[k] - PULSE_US;
        end
        exp_q.push_back(pk(PULSE_LVL, 0, PULSE_US * CLK_DIV));
        sy = (FRAME_US - el > SYNC_MIN_US) ? (FRAME_US - el) : SYNC_MIN_US;
        exp_q.push_back(pk(IDLE_LVL, 0, sy * CLK_DIV + 1));
    endtask

    // Driver: one-cycle Dat_Rdy strobe, called at posedge+1
    task automatic drive_data(input int raw [8]);
        for (int k = 0; k < 8; k++) Dat_In[11*k +: 11] = 11'(raw[k]);
        Dat_Rdy = 1'b1;
        @(posedge CLK); #1;
        Dat_Rdy = 1'b0;
    endtask

    // Raise En and check the IDLE -> LOAD -> PULSE latency
    task automatic start_enable(input string name);
        En = 1'b1;
        @(posedge CLK); #1;
        check_val({name, "_load_sig"}, 32'(Sig_Out), 32'(IDLE_LVL));
        check_val({name, "_load_state"}, 32'(state_dbg), 32'(ST_LOAD));
        @(posedge CLK); #1;
        check_val({name, "_pulse_sig"}, 32'(Sig_Out), 32'(PULSE_LVL));
        check_val({name, "_frame_start"}, 32'(Frame_Start), 32'd1);
    endtask

    task automatic wait_load(input string name);
        int n;
        n = 0;
        while (state_dbg !== ST_LOAD && n < 25000) begin
            @(posedge CLK); #1;
            n++;
        end
        check_val({name, "_reached"}, 32'(state_dbg), 32'(ST_LOAD));
    endtask

    // Monitor: measures every Sig_Out run and compares it with the queue head
    logic run_active = 1'b0;
    logic run_lvl    = 1'b0;
    int   run_len    = 0;
    int   run_fs     = 0;
    int   run_no     = 0;
    logic [31:0] exp_run;
    logic [31:0] act_run;

    always @(negedge CLK) begin
        if (!mon_on) begin
            run_active = 1'b0;
        end else if (!run_active) begin
            if (Sig_Out === PULSE_LVL) begin
                run_active = 1'b1;
                run_lvl    = Sig_Out;
                run_len    = 1;
                run_fs     = (Frame_Start === 1'b1) ? 1 : 0;
            end
        end else if (Sig_Out === run_lvl) begin
            run_len++;
            if (Frame_Start === 1'b1 && run_fs < 7) run_fs++;
        end else begin
            act_run = pk(run_lvl, run_fs, run_len);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL run%0d: got lvl=%0b fs=%0d len=%0d, expected no run",
                         run_no, run_lvl, run_fs, run_len);
            end else begin
                exp_run = exp_q.pop_front();
                if (act_run !== exp_run) begin
                    errors++;
                    $display("FAIL run%0d: got lvl=%0b fs=%0d len=%0d, expected lvl=%0b fs=%0d len=%0d",
                             run_no, run_lvl, run_fs, run_len,
                             exp_run[31], exp_run[30:28], exp_run[27:0]);
                end
            end
            run_no++;
            run_lvl = Sig_Out;
            run_len = 1;
            run_fs  = (Frame_Start === 1'b1) ? 1 : 0;
        end
    end

    // Watchdog
    initial begin
        repeat (100000) @(posedge CLK);
        errors++;
        $display("FAIL watchdog: run exceeded 100000 cycles");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Stimulus
    initial begin
        int n;
        int bad;
        RSTn    = 1'b0;
        En      = 1'b0;
        Dat_Rdy = 1'b0;
        Dat_In  = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_sig", 32'(Sig_Out), 32'(IDLE_LVL));
        check_val("rst_fs", 32'(Frame_Start), 32'd0);
        check_val("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        RSTn = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_val("idle_sig", 32'(Sig_Out), 32'(IDLE_LVL));
        check_val("idle_state", 32'(state_dbg), 32'(ST_IDLE));

        // Frame A: reset defaults
        push_frame(exp_a);
        mon_on = 1'b1;
        start_enable("start_a");

        // Mid-frame strobes: junk, then B overwrites it; A stays unchanged
        repeat (3000) @(posedge CLK);
        #1;
        drive_data(raw_junk);
        repeat (10) @(posedge CLK);
        #1;
        drive_data(raw_b);
        push_frame(exp_b);

        // Strobe C in the LOAD cycle of frame B: B runs, C follows
        wait_load("load_b");
        drive_data(raw_c);
        push_frame(exp_c);

        // Drop En inside the channel-3 space of frame C
        wait_load("load_c");
        repeat (5700) @(posedge CLK);
        #1;
        check_val("drop_in_space", 32'(state_dbg), 32'(ST_SPACE));
        En     = 1'b0;
        mon_on = 1'b0;
        exp_q.delete();
        @(posedge CLK); #1;
        check_val("drop_sig", 32'(Sig_Out), 32'(IDLE_LVL));
        check_val("drop_fs", 32'(Frame_Start), 32'd0);
        check_val("drop_state", 32'(state_dbg), 32'(ST_IDLE));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (Sig_Out !== IDLE_LVL || Frame_Start !== 1'b0) bad++;
        end
        check_val("hold_idle_bad_cycles", 32'(bad), 32'd0);

        // Re-enable: full fresh frame with the retained active set C
        push_frame(exp_c);
        exp_q.push_back(pk(PULSE_LVL, 1, PULSE_US * CLK_DIV));
        mon_on = 1'b1;
        start_enable("restart");

        n = 0;
        while (exp_q.size() > 0 && n < 20000) begin
            @(posedge CLK); #1;
            n++;
        end
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during a pulse aborts immediately
        mon_on = 1'b0;
        n = 0;
        while (Sig_Out !== PULSE_LVL && n < 4000) begin
            @(posedge CLK); #1;
            n++;
        end
        check_val("pre_reset_pulse", 32'(Sig_Out), 32'(PULSE_LVL));
        #2;
        RSTn = 1'b0;
        #1;
        check_val("async_rst_sig", 32'(Sig_Out), 32'(IDLE_LVL));
        check_val("async_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check_val("async_rst_fs", 32'(Frame_Start), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
